// File: rtl/mpu_common_pkg.sv
// Shared MPU types and sizes.
// Holds the core/block/address geometry, the malloc error codes returned to
// cores, the allocator front-end arbiter state encoding and a small helper
// for round-robin index arithmetic.
package mpu_common;

    localparam int CORE_COUNT       = 4;
    localparam int CORE_ID_WIDTH    = $clog2(CORE_COUNT);
    localparam int BLOCK_COUNT_BITS = 8;
    localparam int ADDR_WIDTH       = 16;

    typedef enum logic [1:0] {
        MALLOC_NO_ERROR      = 2'd0,
        MALLOC_OUT_OF_MEMORY = 2'd1,
        MALLOC_BAD_SIZE      = 2'd2,
        MALLOC_TIMEOUT       = 2'd3
    } malloc_error_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WAIT  = 2'd1,
        ARB_RESP  = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_t;

    // Core index 'offset' positions above 'base', wrapping modulo CORE_COUNT.
    function automatic logic [CORE_ID_WIDTH-1:0] rr_index(
        input logic [CORE_ID_WIDTH-1:0] base,
        input int                       offset
    );
        return CORE_ID_WIDTH'((int'(base) + offset) % CORE_COUNT);
    endfunction

endpackage

// File: rtl/malloc_rr_picker.sv
// Combinational round-robin picker.
// Finds the first set bit of req searching upward from rr_ptr+1 and wrapping,
// so the most recent winner (rr_ptr) has the lowest priority.
//   req       : request vector, one bit per core
//   rr_ptr    : index of the previous winner
//   any_valid : at least one request bit is set
//   winner    : selected core index (0 when any_valid is low)
module malloc_rr_picker
    import mpu_common::*;
(
    input  logic [CORE_COUNT-1:0]    req,
    input  logic [CORE_ID_WIDTH-1:0] rr_ptr,
    output logic                     any_valid,
    output logic [CORE_ID_WIDTH-1:0] winner
);

    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        for (int i = 1; i <= CORE_COUNT; i++) begin
            if (!any_valid && req[rr_index(rr_ptr, i)]) begin
                any_valid = 1'b1;
                winner    = rr_index(rr_ptr, i);
            end
        end
    end

endmodule

// File: rtl/malloc_arbiter.sv
// Allocation request front-end for the malloc engine.
// Picks one pending core request round-robin, issues it to malloc with a
// single-cycle chip-select, waits for the result (guarded by a watchdog) and
// returns base address and error code to the owning core.
//   clk, rst                 : clock, synchronous active-high reset
//   req_*                    : per-core request inputs
//   req_ready                : one-hot pulse, request consumed
//   resp_valid/base/err      : one-hot response pulse plus held data
//   m_cs, m_core_id, m_*     : request towards malloc
//   m_rdy, m_bsy, m_base_addr, m_err : malloc result / status
//   dbg_state                : current arbiter state
//
// Handshake: a core holds req_valid and its fields stable until it sees its
// req_ready bit, and drops req_valid on the following edge. The arbiter never
// samples req_valid within two cycles of a grant, so a consumed request cannot
// be granted twice. Responses are fire-and-forget one-cycle pulses.
module malloc_arbiter
    import mpu_common::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [CORE_COUNT-1:0]                          req_valid,
    input  logic [CORE_COUNT-1:0][BLOCK_COUNT_BITS-1:0]    req_num_blocks,
    input  logic [CORE_COUNT-1:0][CORE_COUNT-1:0]          req_read_mask,
    input  logic [CORE_COUNT-1:0][CORE_COUNT-1:0]          req_write_mask,
    output logic [CORE_COUNT-1:0]                          req_ready,
    output logic [CORE_COUNT-1:0]                          resp_valid,
    output logic [ADDR_WIDTH-1:0]                          resp_base_addr,
    output malloc_error_t                                  resp_err,
    output logic                                           m_cs,
    output logic [CORE_ID_WIDTH-1:0]                       m_core_id,
    output logic [BLOCK_COUNT_BITS-1:0]                    m_num_blocks,
    output logic [CORE_COUNT-1:0]                          m_read_mask,
    output logic [CORE_COUNT-1:0]                          m_write_mask,
    input  logic                                           m_rdy,
    input  logic                                           m_bsy,
    input  logic [ADDR_WIDTH-1:0]                          m_base_addr,
    input  malloc_error_t                                  m_err,
    output arb_state_t                                     dbg_state
);

    localparam logic [CORE_COUNT-1:0] ONE_HOT0    = CORE_COUNT'(1);
    localparam logic [TMO_W-1:0]      WD_LAST     = TMO_W'(TIMEOUT_CYCLES - 1);

    arb_state_t                  state_q, state_d;
    logic [CORE_ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]            wd_q, wd_d;
    logic [CORE_COUNT-1:0]       req_ready_q, req_ready_d;
    logic [CORE_COUNT-1:0]       resp_valid_q, resp_valid_d;
    logic [ADDR_WIDTH-1:0]       resp_base_addr_q, resp_base_addr_d;
    malloc_error_t               resp_err_q, resp_err_d;
    logic                        m_cs_q, m_cs_d;
    logic [CORE_ID_WIDTH-1:0]    m_core_id_q, m_core_id_d;
    logic [BLOCK_COUNT_BITS-1:0] m_num_blocks_q, m_num_blocks_d;
    logic [CORE_COUNT-1:0]       m_read_mask_q, m_read_mask_d;
    logic [CORE_COUNT-1:0]       m_write_mask_q, m_write_mask_d;

    logic                        any_valid;
    logic [CORE_ID_WIDTH-1:0]    winner;
    logic [CORE_COUNT-1:0]       owner_onehot;

    malloc_rr_picker u_picker (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .any_valid (any_valid),
        .winner    (winner)
    );

    // The owning core is the one latched onto m_core_id at grant time.
    assign owner_onehot = ONE_HOT0 << m_core_id_q;

    always_comb begin
        state_d          = state_q;
        rr_ptr_d         = rr_ptr_q;
        wd_d             = wd_q;
        req_ready_d      = '0;
        resp_valid_d     = '0;
        resp_base_addr_d = resp_base_addr_q;
        resp_err_d       = resp_err_q;
        m_cs_d           = 1'b0;
        m_core_id_d      = m_core_id_q;
        m_num_blocks_d   = m_num_blocks_q;
        m_read_mask_d    = m_read_mask_q;
        m_write_mask_d   = m_write_mask_q;

        case (state_q)
            ARB_IDLE: begin
                // m_bsy gate: never issue into a malloc still working on a
                // request that was abandoned by reset or timeout.
                if (!m_bsy && any_valid) begin
                    rr_ptr_d       = winner;
                    m_core_id_d    = winner;
                    m_num_blocks_d = req_num_blocks[winner];
                    m_read_mask_d  = req_read_mask[winner];
                    m_write_mask_d = req_write_mask[winner];
                    req_ready_d    = ONE_HOT0 << winner;
                    if (req_num_blocks[winner] == '0) begin
                        resp_err_d       = MALLOC_BAD_SIZE;
                        resp_base_addr_d = '0;
                        resp_valid_d     = ONE_HOT0 << winner;
                        state_d          = ARB_RESP;
                    end else begin
                        m_cs_d  = 1'b1;
                        wd_d    = '0;
                        state_d = ARB_WAIT;
                    end
                end
            end
            ARB_WAIT: begin
                wd_d = wd_q + TMO_W'(1);
                // A result arriving in the timeout cycle still wins.
                if (m_rdy) begin
                    resp_base_addr_d = m_base_addr;
                    resp_err_d       = m_err;
                    resp_valid_d     = owner_onehot;
                    state_d          = ARB_RESP;
                end else if (wd_q == WD_LAST) begin
                    resp_base_addr_d = '0;
                    resp_err_d       = MALLOC_TIMEOUT;
                    resp_valid_d     = owner_onehot;
                    state_d          = ARB_DRAIN;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            ARB_DRAIN: begin
                // Swallow any late result of the timed-out request.
                if (!m_bsy && !m_rdy) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ARB_IDLE;
            rr_ptr_q         <= '0;
            wd_q             <= '0;
            req_ready_q      <= '0;
            resp_valid_q     <= '0;
            resp_base_addr_q <= '0;
            resp_err_q       <= MALLOC_NO_ERROR;
            m_cs_q           <= 1'b0;
            m_core_id_q      <= '0;
            m_num_blocks_q   <= '0;
            m_read_mask_q    <= '0;
            m_write_mask_q   <= '0;
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            wd_q             <= wd_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_base_addr_q <= resp_base_addr_d;
            resp_err_q       <= resp_err_d;
            m_cs_q           <= m_cs_d;
            m_core_id_q      <= m_core_id_d;
            m_num_blocks_q   <= m_num_blocks_d;
            m_read_mask_q    <= m_read_mask_d;
            m_write_mask_q   <= m_write_mask_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_base_addr = resp_base_addr_q;
    assign resp_err       = resp_err_q;
    assign m_cs           = m_cs_q;
    assign m_core_id      = m_core_id_q;
    assign m_num_blocks   = m_num_blocks_q;
    assign m_read_mask    = m_read_mask_q;
    assign m_write_mask   = m_write_mask_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_malloc_arbiter.sv
// Bench for malloc_arbiter: scenario tasks driven from one initial block,
// expected responses queued when stimulus is driven and popped on resp_valid.
module tb_malloc_arbiter;
    import mpu_common::*;

    localparam int TMO   = 16;
    localparam int W     = CORE_COUNT + ADDR_WIDTH + 2;
    localparam int LIMIT = 64;

    logic                                        clk = 1'b0;
    logic                                        rst;
    logic [CORE_COUNT-1:0]                       req_valid;
    logic [CORE_COUNT-1:0][BLOCK_COUNT_BITS-1:0] req_num_blocks;
    logic [CORE_COUNT-1:0][CORE_COUNT-1:0]       req_read_mask;
    logic [CORE_COUNT-1:0][CORE_COUNT-1:0]       req_write_mask;
    logic [CORE_COUNT-1:0]                       req_ready;
    logic [CORE_COUNT-1:0]                       resp_valid;
    logic [ADDR_WIDTH-1:0]                       resp_base_addr;
    malloc_error_t                               resp_err;
    logic                                        m_cs;
    logic [CORE_ID_WIDTH-1:0]                    m_core_id;
    logic [BLOCK_COUNT_BITS-1:0]                 m_num_blocks;
    logic [CORE_COUNT-1:0]                       m_read_mask;
    logic [CORE_COUNT-1:0]                       m_write_mask;
    logic                                        m_rdy;
    logic                                        m_bsy;
    logic [ADDR_WIDTH-1:0]                       m_base_addr;
    malloc_error_t                               m_err;
    arb_state_t                                  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_r, got_r;

    malloc_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_num_blocks (req_num_blocks),
        .req_read_mask  (req_read_mask),
        .req_write_mask (req_write_mask),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_base_addr (resp_base_addr),
        .resp_err       (resp_err),
        .m_cs           (m_cs),
        .m_core_id      (m_core_id),
        .m_num_blocks   (m_num_blocks),
        .m_read_mask    (m_read_mask),
        .m_write_mask   (m_write_mask),
        .m_rdy          (m_rdy),
        .m_bsy          (m_bsy),
        .m_base_addr    (m_base_addr),
        .m_err          (m_err),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        rst            = 1'b0;
        req_valid      = '0;
        req_num_blocks = '0;
        req_read_mask  = '0;
        req_write_mask = '0;
        m_rdy          = 1'b0;
        m_bsy          = 1'b0;
        m_base_addr    = '0;
        m_err          = MALLOC_NO_ERROR;
    endtask

    task automatic present(input int core, input int nblk);
        req_num_blocks[core] = BLOCK_COUNT_BITS'(nblk);
        req_read_mask[core]  = CORE_COUNT'($urandom_range(0, 15));
        req_write_mask[core] = CORE_COUNT'($urandom_range(0, 15));
        req_valid[core]      = 1'b1;
    endtask

    // One-cycle malloc result strobe; returns in the cycle after the strobe.
    task automatic malloc_result(input logic [ADDR_WIDTH-1:0] addr, input malloc_error_t err);
        m_rdy       = 1'b1;
        m_base_addr = addr;
        m_err       = err;
        tick();
        m_rdy       = 1'b0;
        m_base_addr = ADDR_WIDTH'($urandom_range(0, 65535));
        m_err       = MALLOC_NO_ERROR;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (req_ready == '0 && n < LIMIT) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (resp_valid == '0 && n < LIMIT) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_cs(output int n);
        n = 0;
        while (!m_cs && n < LIMIT) begin
            tick();
            n++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req_valid = '1;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (req_ready !== '0 || resp_valid !== '0 || m_cs !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: ready=%b resp=%b cs=%b required 0", req_ready, resp_valid, m_cs);
        end
        checks++;
        if (resp_base_addr !== '0 || resp_err !== MALLOC_NO_ERROR) begin
            errors++;
            $display("FAIL reset_resp: addr=%h err=%0d required 0/0", resp_base_addr, resp_err);
        end
        checks++;
        if (m_core_id !== '0 || m_num_blocks !== '0 || m_read_mask !== '0 || m_write_mask !== '0) begin
            errors++;
            $display("FAIL reset_mfields: id=%0d nb=%0d rm=%b wm=%b required 0", m_core_id, m_num_blocks, m_read_mask, m_write_mask);
        end
        checks++;
        if (dbg_state !== ARB_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, ARB_IDLE);
        end
        req_valid = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        present(2, 3);
        wait_ready(n);
        req_valid[2] = 1'b0;
        checks++;
        if (req_ready !== 4'b0100 || n !== 1) begin
            errors++;
            $display("FAIL single_ready: ready=%b after %0d cycles, required 0100 after 1", req_ready, n);
        end
        checks++;
        if (m_cs !== 1'b1 || m_core_id !== 2'd2 || m_num_blocks !== 8'd3) begin
            errors++;
            $display("FAIL single_issue: cs=%b id=%0d nb=%0d required 1/2/3", m_cs, m_core_id, m_num_blocks);
        end
        checks++;
        if (m_read_mask !== req_read_mask[2] || m_write_mask !== req_write_mask[2]) begin
            errors++;
            $display("FAIL single_masks: rm=%b wm=%b required %b/%b", m_read_mask, m_write_mask, req_read_mask[2], req_write_mask[2]);
        end
        m_bsy = 1'b1;
        exp_q.push_back({4'b0100, 16'h0300, MALLOC_NO_ERROR});
        tick();
        checks++;
        if (m_cs !== 1'b0 || req_ready !== '0) begin
            errors++;
            $display("FAIL single_pulse_width: cs=%b ready=%b required 0/0000", m_cs, req_ready);
        end
        tick();
        m_bsy = 1'b0;
        malloc_result(16'h0300, MALLOC_NO_ERROR);
        wait_resp(n);
        got_r = {resp_valid, resp_base_addr, resp_err};
        exp_r = exp_q.pop_front();
        checks++;
        if (got_r !== exp_r || n !== 0) begin
            errors++;
            $display("FAIL single_resp: got %h after %0d extra cycles, required %h after 0", got_r, n, exp_r);
        end
        tick();
        checks++;
        if (resp_valid !== '0 || resp_base_addr !== 16'h0300) begin
            errors++;
            $display("FAIL single_resp_hold: resp=%b addr=%h required 0000/0300", resp_valid, resp_base_addr);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int order[5] = '{1, 2, 3, 0, 1};
        logic [CORE_COUNT-1:0] oh;
        logic [ADDR_WIDTH-1:0] a;
        pulse_reset();
        for (int c = 0; c < CORE_COUNT; c++) present(c, c + 1);
        for (int g = 0; g < 5; g++) begin
            wait_ready(n);
            oh = CORE_COUNT'(1) << order[g];
            checks++;
            if (req_ready !== oh || m_core_id !== CORE_ID_WIDTH'(order[g]) || m_num_blocks !== BLOCK_COUNT_BITS'(order[g] + 1)) begin
                errors++;
                $display("FAIL rr_grant%0d: ready=%b id=%0d nb=%0d required %b/%0d/%0d", g, req_ready, m_core_id, m_num_blocks, oh, order[g], order[g] + 1);
            end
            req_valid[order[g]] = 1'b0;
            a = ADDR_WIDTH'(order[g] * 256 + g);
            exp_q.push_back({oh, a, MALLOC_NO_ERROR});
            tick();
            tick();
            malloc_result(a, MALLOC_NO_ERROR);
            wait_resp(n);
            got_r = {resp_valid, resp_base_addr, resp_err};
            exp_r = exp_q.pop_front();
            checks++;
            if (got_r !== exp_r) begin
                errors++;
                $display("FAIL rr_resp%0d: got %h required %h", g, got_r, exp_r);
            end
            req_valid[order[g]] = 1'b1;
        end
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_zero_size();
        int n;
        logic cs_seen;
        present(0, 0);
        wait_ready(n);
        req_valid[0] = 1'b0;
        cs_seen = m_cs;
        checks++;
        if (req_ready !== 4'b0001 || n !== 1) begin
            errors++;
            $display("FAIL zero_ready: ready=%b after %0d, required 0001 after 1", req_ready, n);
        end
        exp_q.push_back({4'b0001, 16'h0000, MALLOC_BAD_SIZE});
        got_r = {resp_valid, resp_base_addr, resp_err};
        exp_r = exp_q.pop_front();
        checks++;
        if (got_r !== exp_r) begin
            errors++;
            $display("FAIL zero_resp: got %h required %h", got_r, exp_r);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            cs_seen = cs_seen | m_cs;
        end
        checks++;
        if (cs_seen !== 1'b0 || dbg_state !== ARB_IDLE) begin
            errors++;
            $display("FAIL zero_no_cs: cs_seen=%b state=%0d required 0/%0d", cs_seen, dbg_state, ARB_IDLE);
        end
    endtask

    task automatic test_timeout();
        int n;
        logic seen_ready, seen_resp;
        present(1, 2);
        wait_cs(n);
        req_valid[1] = 1'b0;
        m_bsy = 1'b1;
        checks++;
        if (m_cs !== 1'b1 || m_core_id !== 2'd1) begin
            errors++;
            $display("FAIL tmo_issue: cs=%b id=%0d required 1/1", m_cs, m_core_id);
        end
        exp_q.push_back({4'b0010, 16'h0000, MALLOC_TIMEOUT});
        wait_resp(n);
        got_r = {resp_valid, resp_base_addr, resp_err};
        exp_r = exp_q.pop_front();
        checks++;
        if (got_r !== exp_r || n !== TMO) begin
            errors++;
            $display("FAIL tmo_resp: got %h after %0d cycles, required %h after %0d", got_r, n, exp_r, TMO);
        end
        checks++;
        if (dbg_state !== ARB_DRAIN) begin
            errors++;
            $display("FAIL tmo_state: got %0d required %0d", dbg_state, ARB_DRAIN);
        end
        present(3, 4);
        seen_ready = 1'b0;
        seen_resp  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                m_rdy       = 1'b1;
                m_base_addr = 16'h0777;
            end
            if (i == 2) m_rdy = 1'b0;
            tick();
            seen_ready = seen_ready | (req_ready != '0);
            seen_resp  = seen_resp | (resp_valid != '0);
        end
        checks++;
        if (seen_ready !== 1'b0 || seen_resp !== 1'b0) begin
            errors++;
            $display("FAIL tmo_drain: ready_seen=%b resp_seen=%b required 0/0", seen_ready, seen_resp);
        end
        m_bsy = 1'b0;
        wait_ready(n);
        req_valid[3] = 1'b0;
        checks++;
        if (req_ready !== 4'b1000 || n !== 2) begin
            errors++;
            $display("FAIL tmo_regrant: ready=%b after %0d, required 1000 after 2", req_ready, n);
        end
        exp_q.push_back({4'b1000, 16'h0400, MALLOC_NO_ERROR});
        tick();
        malloc_result(16'h0400, MALLOC_NO_ERROR);
        wait_resp(n);
        got_r = {resp_valid, resp_base_addr, resp_err};
        exp_r = exp_q.pop_front();
        checks++;
        if (got_r !== exp_r) begin
            errors++;
            $display("FAIL tmo_next_resp: got %h required %h", got_r, exp_r);
        end
        tick();
    endtask

    task automatic test_busy_collision();
        int n;
        logic seen;
        m_bsy = 1'b1;
        present(2, 1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | (req_ready != '0) | m_cs;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL busy_gate: grant seen=%b required 0", seen);
        end
        m_bsy = 1'b0;
        wait_ready(n);
        req_valid[2] = 1'b0;
        checks++;
        if (req_ready !== 4'b0100 || m_cs !== 1'b1 || n !== 1) begin
            errors++;
            $display("FAIL busy_release: ready=%b cs=%b after %0d, required 0100/1 after 1", req_ready, m_cs, n);
        end
        repeat (TMO - 1) tick();
        exp_q.push_back({4'b0100, 16'h01A0, MALLOC_OUT_OF_MEMORY});
        malloc_result(16'h01A0, MALLOC_OUT_OF_MEMORY);
        got_r = {resp_valid, resp_base_addr, resp_err};
        exp_r = exp_q.pop_front();
        checks++;
        if (got_r !== exp_r || dbg_state !== ARB_RESP) begin
            errors++;
            $display("FAIL collision_resp: got %h state %0d, required %h state %0d", got_r, dbg_state, exp_r, ARB_RESP);
        end
        tick();
        checks++;
        if (dbg_state !== ARB_IDLE) begin
            errors++;
            $display("FAIL collision_idle: state %0d required %0d", dbg_state, ARB_IDLE);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        present(1, 5);
        wait_cs(n);
        req_valid[1] = 1'b0;
        repeat (3) tick();
        checks++;
        if (dbg_state !== ARB_WAIT) begin
            errors++;
            $display("FAIL midrst_pre: state %0d required %0d", dbg_state, ARB_WAIT);
        end
        pulse_reset();
        checks++;
        if (req_ready !== '0 || resp_valid !== '0 || m_cs !== 1'b0 || resp_base_addr !== '0 || resp_err !== MALLOC_NO_ERROR) begin
            errors++;
            $display("FAIL midrst_out: ready=%b resp=%b cs=%b addr=%h err=%0d required all 0", req_ready, resp_valid, m_cs, resp_base_addr, resp_err);
        end
        checks++;
        if (m_core_id !== '0 || m_num_blocks !== '0 || m_read_mask !== '0 || m_write_mask !== '0 || dbg_state !== ARB_IDLE) begin
            errors++;
            $display("FAIL midrst_m: id=%0d nb=%0d rm=%b wm=%b state=%0d required all 0", m_core_id, m_num_blocks, m_read_mask, m_write_mask, dbg_state);
        end
        present(1, 5);
        wait_ready(n);
        req_valid[1] = 1'b0;
        checks++;
        if (req_ready !== 4'b0010 || m_cs !== 1'b1 || m_core_id !== 2'd1 || m_num_blocks !== 8'd5) begin
            errors++;
            $display("FAIL midrst_regrant: ready=%b cs=%b id=%0d nb=%0d required 0010/1/1/5", req_ready, m_cs, m_core_id, m_num_blocks);
        end
        exp_q.push_back({4'b0010, 16'h0500, MALLOC_NO_ERROR});
        tick();
        malloc_result(16'h0500, MALLOC_NO_ERROR);
        wait_resp(n);
        got_r = {resp_valid, resp_base_addr, resp_err};
        exp_r = exp_q.pop_front();
        checks++;
        if (got_r !== exp_r) begin
            errors++;
            $display("FAIL midrst_resp: got %h required %h", got_r, exp_r);
        end
        tick();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        drive_idle();
        test_reset();
        test_single();
        test_round_robin();
        test_zero_size();
        test_timeout();
        test_busy_collision();
        test_reset_mid_wait();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, required completion");
        $fatal(1, "bench time limit expired");
    end

endmodule
